// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signal bundle for bram_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  r0_req;
    logic                  r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic                  r1_we;
    logic                  r1_lock;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  mem_q,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_addr, mem_data, mem_we
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output mem_q,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the CPU (r0) and the graphics
// fetch engine (r1), with capped r1 burst locking and read-data steering.
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bram_port_arbiter_if.slave    bus
);
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    lock_state_t state_r;
    logic [7:0]  lock_cnt_r;
    logic        last_r;
    logic        rd_pend_r;
    logic        rd_who_r;

    logic        lock_hold_s;
    logic        r0_gnt_s;
    logic        r1_gnt_s;
    logic        acc0_s;
    logic        acc1_s;
    logic [7:0]  lock_cnt_inc_s;

    // Grant selection: a held lock beats round-robin; a dropped r1_req frees the port at once.
    always_comb begin
        lock_hold_s = (state_r == LOCKED) && bus.r1_req;
        r0_gnt_s    = 1'b0;
        r1_gnt_s    = 1'b0;
        if (reset) begin
            r0_gnt_s = 1'b0;
            r1_gnt_s = 1'b0;
        end else if (lock_hold_s) begin
            r1_gnt_s = 1'b1;
        end else if (bus.r0_req && bus.r1_req) begin
            r0_gnt_s = last_r;
            r1_gnt_s = ~last_r;
        end else begin
            r0_gnt_s = bus.r0_req;
            r1_gnt_s = bus.r1_req;
        end
    end

    assign acc0_s         = bus.r0_req && r0_gnt_s;
    assign acc1_s         = bus.r1_req && r1_gnt_s;
    assign lock_cnt_inc_s = (lock_cnt_r == 8'hFF) ? 8'hFF : (lock_cnt_r + 8'd1);

    assign bus.r0_gnt    = r0_gnt_s;
    assign bus.r1_gnt    = r1_gnt_s;
    assign bus.r0_rvalid = rd_pend_r && (rd_who_r == 1'b0);
    assign bus.r1_rvalid = rd_pend_r && (rd_who_r == 1'b1);
    assign bus.r0_rdata  = bus.mem_q;
    assign bus.r1_rdata  = bus.mem_q;

    // BRAM port mux; the port is driven to all zeros when nobody holds a grant.
    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        case ({r1_gnt_s, r0_gnt_s})
            2'b01: begin
                bus.mem_we   = bus.r0_we;
                bus.mem_addr = bus.r0_addr;
                bus.mem_data = bus.r0_wdata;
            end
            2'b10: begin
                bus.mem_we   = bus.r1_we;
                bus.mem_addr = bus.r1_addr;
                bus.mem_data = bus.r1_wdata;
            end
            default: begin
                bus.mem_we   = 1'b0;
                bus.mem_addr = '0;
                bus.mem_data = '0;
            end
        endcase
    end

    // Round-robin history, read-return tags and the r1 lock state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= UNLOCKED;
            lock_cnt_r <= 8'd0;
            last_r     <= 1'b1;
            rd_pend_r  <= 1'b0;
            rd_who_r   <= 1'b0;
        end else begin
            rd_pend_r <= (acc0_s && !bus.r0_we) || (acc1_s && !bus.r1_we);
            rd_who_r  <= acc1_s;

            if (acc0_s) begin
                last_r <= 1'b0;
            end else if (acc1_s) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end

            // The beat that opens a lock counts as the first of the burst.
            case (state_r)
                UNLOCKED: begin
                    if (acc1_s && bus.r1_lock && (8'd1 < LOCK_MAX_C)) begin
                        state_r    <= LOCKED;
                        lock_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= UNLOCKED;
                        lock_cnt_r <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (!bus.r1_req) begin
                        state_r    <= UNLOCKED;
                        lock_cnt_r <= 8'd0;
                    end else if (acc1_s && (!bus.r1_lock || (lock_cnt_inc_s >= LOCK_MAX_C))) begin
                        state_r    <= UNLOCKED;
                        lock_cnt_r <= 8'd0;
                    end else if (acc1_s) begin
                        state_r    <= LOCKED;
                        lock_cnt_r <= lock_cnt_inc_s;
                    end else begin
                        state_r    <= LOCKED;
                        lock_cnt_r <= lock_cnt_r;
                    end
                end
                default: begin
                    state_r    <= UNLOCKED;
                    lock_cnt_r <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (LOCK_MAX 16 and 4) share one stimulus
// stream, each with its own BRAM, behavioural model and literal spot checks.
module tb_bram_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic          r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;

    int vectors     = 0;
    int miscompares = 0;

    bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.r0_req = r0_req;   assign bus_b.r0_req = r0_req;
    assign bus_a.r0_we  = r0_we;    assign bus_b.r0_we  = r0_we;
    assign bus_a.r0_addr = r0_addr; assign bus_b.r0_addr = r0_addr;
    assign bus_a.r0_wdata = r0_wdata; assign bus_b.r0_wdata = r0_wdata;
    assign bus_a.r1_req = r1_req;   assign bus_b.r1_req = r1_req;
    assign bus_a.r1_we  = r1_we;    assign bus_b.r1_we  = r1_we;
    assign bus_a.r1_lock = r1_lock; assign bus_b.r1_lock = r1_lock;
    assign bus_a.r1_addr = r1_addr; assign bus_b.r1_addr = r1_addr;
    assign bus_a.r1_wdata = r1_wdata; assign bus_b.r1_wdata = r1_wdata;

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    // Registered-output BRAMs, preloaded so every address has a known value.
    logic [DW-1:0] ram_a [0:65535];
    logic [DW-1:0] ram_b [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_a[i] = init_val(16'(i));
            ram_b[i] = init_val(16'(i));
        end
    end
    always @(posedge clk) begin
        if (bus_a.mem_we) ram_a[bus_a.mem_addr] <= bus_a.mem_data;
        bus_a.mem_q <= ram_a[bus_a.mem_addr];
        if (bus_b.mem_we) ram_b[bus_b.mem_addr] <= bus_b.mem_data;
        bus_b.mem_q <= ram_b[bus_b.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural model: who owns the port, whether r1 is in a burst, and the read due next cycle.
    logic          m_last   [2];
    logic          m_burst  [2];
    int            m_beats  [2];
    logic          m_pend   [2];
    logic          m_who    [2];
    logic [DW-1:0] m_data   [2];
    int            m_cap    [2];
    logic [DW-1:0] shadow   [int];

    function automatic logic [15:0] model_read(input int d, input logic [15:0] a);
        int key;
        key = d * 65536 + int'(a);
        if (shadow.exists(key)) return shadow[key];
        return init_val(a);
    endfunction

    function automatic logic [1:0] model_grant(input int d);
        if (reset) return 2'b00;
        if (m_burst[d] && r1_req) return 2'b10;
        if (r0_req && r1_req) return m_last[d] ? 2'b01 : 2'b10;
        return {r1_req, r0_req};
    endfunction

    initial begin
        m_cap[0] = 16;
        m_cap[1] = 4;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [1:0]    g, dg, rv, erv;
                logic          dwe, ewe;
                logic [AW-1:0] daddr, eaddr;
                logic [DW-1:0] ddata, edata, drd;
                string         tag;
                tag = (d == 0) ? "A" : "B";
                if (reset) begin
                    m_last[d] = 1'b1; m_burst[d] = 1'b0; m_beats[d] = 0; m_pend[d] = 1'b0;
                end
                g = model_grant(d);
                if (d == 0) begin
                    dg = {bus_a.r1_gnt, bus_a.r0_gnt}; dwe = bus_a.mem_we;
                    daddr = bus_a.mem_addr; ddata = bus_a.mem_data;
                    rv = {bus_a.r1_rvalid, bus_a.r0_rvalid};
                    drd = m_who[d] ? bus_a.r1_rdata : bus_a.r0_rdata;
                end else begin
                    dg = {bus_b.r1_gnt, bus_b.r0_gnt}; dwe = bus_b.mem_we;
                    daddr = bus_b.mem_addr; ddata = bus_b.mem_data;
                    rv = {bus_b.r1_rvalid, bus_b.r0_rvalid};
                    drd = m_who[d] ? bus_b.r1_rdata : bus_b.r0_rdata;
                end
                ewe = 1'b0; eaddr = '0; edata = '0;
                if (g == 2'b01) begin ewe = r0_we; eaddr = r0_addr; edata = r0_wdata; end
                if (g == 2'b10) begin ewe = r1_we; eaddr = r1_addr; edata = r1_wdata; end
                erv = m_pend[d] ? (m_who[d] ? 2'b10 : 2'b01) : 2'b00;
                check({tag, " model gnt"}, 32'(dg), 32'(g));
                check({tag, " model mem_we"}, 32'(dwe), 32'(ewe));
                check({tag, " model mem_addr"}, 32'(daddr), 32'(eaddr));
                check({tag, " model mem_data"}, 32'(ddata), 32'(edata));
                check({tag, " model rvalid"}, 32'(rv), 32'(erv));
                if (m_pend[d]) check({tag, " model rdata"}, 32'(drd), 32'(m_data[d]));
                // Advance the model to what the coming edge will do.
                if (!reset) begin
                    m_pend[d] = (g[0] && !r0_we) || (g[1] && !r1_we);
                    m_who[d]  = g[1];
                    m_data[d] = g[1] ? model_read(d, r1_addr) : model_read(d, r0_addr);
                    if (g[0] && r0_we) shadow[d * 65536 + int'(r0_addr)] = r0_wdata;
                    if (g[1] && r1_we) shadow[d * 65536 + int'(r1_addr)] = r1_wdata;
                    if (g[0]) m_last[d] = 1'b0;
                    if (g[1]) m_last[d] = 1'b1;
                    if (m_burst[d]) begin
                        if (!r1_req) m_burst[d] = 1'b0;
                        else if (g[1]) begin
                            m_beats[d] = m_beats[d] + 1;
                            if (!r1_lock || m_beats[d] >= m_cap[d]) m_burst[d] = 1'b0;
                        end
                    end else if (g[1] && r1_lock && m_cap[d] > 1) begin
                        m_burst[d] = 1'b1;
                        m_beats[d] = 1;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesting: no grants, no rvalid, no write strobe.
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 16'h0010; r1_addr = 16'h0020;
        @(negedge clk);
        check("rst r0_gnt", 32'(bus_a.r0_gnt), 32'd0);
        check("rst r1_gnt", 32'(bus_a.r1_gnt), 32'd0);
        check("rst rvalid", 32'({bus_a.r1_rvalid, bus_a.r0_rvalid}), 32'd0);
        check("rst mem_we", 32'(bus_a.mem_we), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Contention: alternating grants starting with r0, data one cycle later.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont r0_gnt", 32'(bus_a.r0_gnt), 32'((i % 2) == 0));
            check("cont r1_gnt", 32'(bus_a.r1_gnt), 32'((i % 2) == 1));
            if (i > 0) begin
                check("cont r0_rvalid", 32'(bus_a.r0_rvalid), 32'(((i - 1) % 2) == 0));
                check("cont rdata", 32'(bus_a.r0_rdata),
                      ((i - 1) % 2 == 0) ? 32'h5A10 : 32'h5A20);
            end
            next_cycle();
        end

        // Solo write then read of 0x0050.
        r1_req = 1'b0; r0_we = 1'b1; r0_addr = 16'h0050; r0_wdata = 16'hBEEF;
        @(negedge clk);
        check("solo wr gnt", 32'(bus_a.r0_gnt), 32'd1);
        check("solo wr mem_we", 32'(bus_a.mem_we), 32'd1);
        check("solo wr mem_addr", 32'(bus_a.mem_addr), 32'h0050);
        next_cycle();
        r0_we = 1'b0;
        @(negedge clk);
        check("solo rd gnt", 32'(bus_a.r0_gnt), 32'd1);
        check("solo rd early rvalid", 32'(bus_a.r0_rvalid), 32'd0);
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        check("solo r0_rvalid", 32'(bus_a.r0_rvalid), 32'd1);
        check("solo r0_rdata", 32'(bus_a.r0_rdata), 32'hBEEF);
        check("solo r1_rvalid", 32'(bus_a.r1_rvalid), 32'd0);
        next_cycle();

        // Locked burst of 5 r1 reads against a waiting r0.
        r0_req = 1'b1; r0_addr = 16'h0030; r1_req = 1'b1; r1_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            r1_addr = 16'h0100 + 16'(k);
            r1_lock = (k < 4);
            @(negedge clk);
            check("burst r1_gnt", 32'(bus_a.r1_gnt), 32'd1);
            if (k > 0) check("burst rdata", 32'(bus_a.r1_rdata), 32'h5B00 + 32'(k - 1));
            next_cycle();
        end
        r1_req = 1'b0; r1_lock = 1'b0;
        @(negedge clk);
        check("burst then r0", 32'(bus_a.r0_gnt), 32'd1);
        check("burst last rvalid", 32'(bus_a.r1_rvalid), 32'd1);
        next_cycle();

        // Starvation cap: lock stuck high, r0 waiting.
        r0_addr = 16'h0030; r1_req = 1'b1; r1_lock = 1'b1; r1_addr = 16'h0200;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("cap B r1_gnt", 32'(bus_b.r1_gnt), 32'((i % 5) != 4));
            check("cap B r0_gnt", 32'(bus_b.r0_gnt), 32'((i % 5) == 4));
            check("cap A r1_gnt", 32'(bus_a.r1_gnt), 32'd1);
            next_cycle();
        end
        r1_req = 1'b0; r1_lock = 1'b0;
        @(negedge clk);
        check("unlock on drop", 32'(bus_a.r0_gnt), 32'd1);
        next_cycle();

        // Reset between an accepted r1 read and its data.
        r0_req = 1'b0; r1_req = 1'b1; r1_addr = 16'h0040;
        @(negedge clk);
        check("mid r1_gnt", 32'(bus_a.r1_gnt), 32'd1);
        next_cycle();
        reset = 1'b1; r0_req = 1'b1; r1_req = 1'b1;
        @(negedge clk);
        check("mid r1_rvalid", 32'(bus_a.r1_rvalid), 32'd0);
        check("mid gnts", 32'({bus_a.r1_gnt, bus_a.r0_gnt}), 32'd0);
        check("mid B r1_rvalid", 32'(bus_b.r1_rvalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post rst tie", 32'({bus_a.r1_gnt, bus_a.r0_gnt}), 32'd1);
        check("post rst tie B", 32'({bus_b.r1_gnt, bus_b.r0_gnt}), 32'd1);
        next_cycle();
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk);
        check("post rst r0_rvalid", 32'(bus_a.r0_rvalid), 32'd1);
        next_cycle();

        // Idle: port parked at zero, no read returns.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle mem_we", 32'(bus_a.mem_we), 32'd0);
            check("idle mem_addr", 32'(bus_a.mem_addr), 32'd0);
            check("idle rvalid", 32'({bus_a.r1_rvalid, bus_a.r0_rvalid}), 32'd0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
